// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared condition codes, counter states and helpers for branch resolution
package branch_pkg;

    // Branch condition codes
    localparam logic [2:0] BR_EQ     = 3'b000;
    localparam logic [2:0] BR_NE     = 3'b001;
    localparam logic [2:0] BR_NEVER  = 3'b010;
    localparam logic [2:0] BR_ALWAYS = 3'b011;
    localparam logic [2:0] BR_LT     = 3'b100;
    localparam logic [2:0] BR_GE     = 3'b101;
    localparam logic [2:0] BR_LTU    = 3'b110;
    localparam logic [2:0] BR_GEU    = 3'b111;

    // Two-bit saturating predictor counter states
    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Unconditional codes never train the predictor or count as branches
    function automatic logic is_conditional(input logic [2:0] cond);
        return (cond != BR_NEVER) && (cond != BR_ALWAYS);
    endfunction

    // Saturating step of a predictor counter towards the resolved direction
    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic dir);
        if (dir) begin
            return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        end
        return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// rtl/branch_cond_eval.sv - combinational XLEN-wide branch condition evaluator
module branch_cond_eval
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      cond,
    output logic            taken
);

    logic eq;
    logic ltu;
    logic lt;

    assign eq  = (a == b);
    assign ltu = (a < b);
    // Differing sign bits decide a signed compare directly; otherwise the unsigned order holds
    assign lt  = (a[XLEN-1] != b[XLEN-1]) ? a[XLEN-1] : ltu;

    // Select the comparison result named by the condition code
    always_comb begin
        taken = 1'b0;
        case (cond)
            BR_EQ:     taken = eq;
            BR_NE:     taken = !eq;
            BR_LT:     taken = lt;
            BR_GE:     taken = !lt;
            BR_LTU:    taken = ltu;
            BR_GEU:    taken = !ltu;
            BR_NEVER:  taken = 1'b0;
            BR_ALWAYS: taken = 1'b1;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - pipelined branch resolver with BHT training and statistics
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int BHT_IDX = 6,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [XLEN-1:0]  imm,
    input  logic [2:0]       branch_cond,
    input  logic             pred_taken,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             taken,
    output logic [XLEN-1:0]  target,
    output logic [XLEN-1:0]  next_pc,
    output logic             mispredict,
    input  logic [XLEN-1:0]  lookup_pc,
    output logic             lookup_taken,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispred
);

    localparam int BHT_N = 1 << BHT_IDX;

    logic [BHT_N-1:0][1:0] bht;
    logic                  cond_taken;
    logic                  accept;
    logic                  train;
    logic [XLEN-1:0]       target_c;
    logic [XLEN-1:0]       seq_pc;
    logic [BHT_IDX-1:0]    wr_idx;
    logic [BHT_IDX-1:0]    rd_idx;
    logic                  unused_lookup_bits;

    branch_cond_eval #(
        .XLEN (XLEN)
    ) u_cond_eval (
        .a     (a),
        .b     (b),
        .cond  (branch_cond),
        .taken (cond_taken)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign train    = accept && is_conditional(branch_cond);

    assign target_c = pc + imm;
    assign seq_pc   = pc + XLEN'(4);

    assign wr_idx = pc[BHT_IDX+1:2];
    assign rd_idx = lookup_pc[BHT_IDX+1:2];

    // Read port sees the array before this cycle's write lands
    assign lookup_taken = bht[rd_idx][1];

    // Only the word-aligned index bits of the fetch query select an entry
    assign unused_lookup_bits = ^{lookup_pc[XLEN-1:BHT_IDX+2], lookup_pc[1:0]};

    // Single result register: load on accept, drop on consume or flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            taken      <= 1'b0;
            target     <= '0;
            next_pc    <= '0;
            mispredict <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            taken      <= cond_taken;
            target     <= target_c;
            next_pc    <= cond_taken ? target_c : seq_pc;
            mispredict <= (cond_taken != pred_taken);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Train the indexed predictor counter on each accepted conditional branch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bht <= {BHT_N{CTR_WNT}};
        end else if (train) begin
            bht[wr_idx] <= ctr_update(bht[wr_idx], cond_taken);
        end
    end

    // Saturating branch and mispredict counters for accepted conditional branches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else if (train) begin
            if (stat_branches != '1) begin
                stat_branches <= stat_branches + CNT_W'(1);
            end
            if ((cond_taken != pred_taken) && (stat_mispred != '1)) begin
                stat_mispred <= stat_mispred + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [2:0]  branch_cond;
    logic        pred_taken;
    logic        out_ready;
    logic [31:0] lookup_pc;

    logic        in_ready;
    logic        out_valid;
    logic        taken;
    logic [31:0] target;
    logic [31:0] next_pc;
    logic        mispredict;
    logic        lookup_taken;
    logic [15:0] stat_branches;
    logic [15:0] stat_mispred;

    logic        in_ready4;
    logic        out_valid4;
    logic        taken4;
    logic [31:0] target4;
    logic [31:0] next_pc4;
    logic        mispredict4;
    logic        lookup_taken4;
    logic [3:0]  stat_branches4;
    logic [3:0]  stat_mispred4;

    branch_resolve_unit #(.XLEN(32), .BHT_IDX(6), .CNT_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .pc            (pc),
        .a             (a),
        .b             (b),
        .imm           (imm),
        .branch_cond   (branch_cond),
        .pred_taken    (pred_taken),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .taken         (taken),
        .target        (target),
        .next_pc       (next_pc),
        .mispredict    (mispredict),
        .lookup_pc     (lookup_pc),
        .lookup_taken  (lookup_taken),
        .stat_branches (stat_branches),
        .stat_mispred  (stat_mispred)
    );

    branch_resolve_unit #(.XLEN(32), .BHT_IDX(6), .CNT_W(4)) dut4 (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready4),
        .pc            (pc),
        .a             (a),
        .b             (b),
        .imm           (imm),
        .branch_cond   (branch_cond),
        .pred_taken    (pred_taken),
        .out_valid     (out_valid4),
        .out_ready     (out_ready),
        .taken         (taken4),
        .target        (target4),
        .next_pc       (next_pc4),
        .mispredict    (mispredict4),
        .lookup_pc     (lookup_pc),
        .lookup_taken  (lookup_taken4),
        .stat_branches (stat_branches4),
        .stat_mispred  (stat_mispred4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: the result slot, the predictor table and raw event counts
    logic        m_valid;
    logic        m_taken;
    logic        m_mis;
    logic [31:0] m_target;
    logic [31:0] m_next;
    int          m_bht [64];
    int          m_br;
    int          m_mp;

    int          t1_codes [8] = '{0, 1, 4, 5, 6, 7, 2, 3};
    int          t1_exp   [8] = '{0, 1, 1, 0, 0, 1, 0, 1};
    logic [31:0] edge_vals [6] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0001};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic ref_taken(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
        case (c)
            3'd0: return x == y;
            3'd1: return x != y;
            3'd2: return 1'b0;
            3'd3: return 1'b1;
            3'd4: return int'(x) <  int'(y);
            3'd5: return int'(x) >= int'(y);
            3'd6: return x <  y;
            default: return x >= y;
        endcase
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_reset();
        m_valid  = 1'b0;
        m_taken  = 1'b0;
        m_mis    = 1'b0;
        m_target = 32'h0;
        m_next   = 32'h0;
        for (int i = 0; i < 64; i++) m_bht[i] = 1;
        m_br = 0;
        m_mp = 0;
    endtask

    // Compare everything against the model, then advance one clock and update the model
    task automatic tick();
        logic        acc;
        logic        t;
        logic [31:0] tg;
        #1;
        check("in_ready", in_ready, !m_valid || out_ready);
        check("lookup_taken", lookup_taken, m_bht[lookup_pc[7:2]] >= 2);
        check("out_valid", out_valid, m_valid);
        check("out_valid_cnt4", out_valid4, m_valid);
        if (m_valid) begin
            check("taken", taken, m_taken);
            check("target", target, m_target);
            check("next_pc", next_pc, m_next);
            check("mispredict", mispredict, m_mis);
        end
        check("stat_branches", stat_branches, sat(m_br, 65535));
        check("stat_mispred", stat_mispred, sat(m_mp, 65535));
        check("stat_branches_cnt4", stat_branches4, sat(m_br, 15));
        check("stat_mispred_cnt4", stat_mispred4, sat(m_mp, 15));
        acc = in_valid && (!m_valid || out_ready) && !flush;
        t   = ref_taken(branch_cond, a, b);
        tg  = pc + imm;
        @(posedge clk);
        if (flush) begin
            m_valid = 1'b0;
        end else if (acc) begin
            m_valid  = 1'b1;
            m_taken  = t;
            m_target = tg;
            m_next   = t ? tg : pc + 32'd4;
            m_mis    = (t != pred_taken);
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        if (acc && branch_cond != 3'd2 && branch_cond != 3'd3) begin
            if (t) m_bht[pc[7:2]] = (m_bht[pc[7:2]] == 3) ? 3 : m_bht[pc[7:2]] + 1;
            else   m_bht[pc[7:2]] = (m_bht[pc[7:2]] == 0) ? 0 : m_bht[pc[7:2]] - 1;
            m_br++;
            if (t != pred_taken) m_mp++;
        end
        #1;
    endtask

    task automatic set_req(input logic [2:0] c, input logic [31:0] pcv, input logic [31:0] av,
                           input logic [31:0] bv, input logic [31:0] iv, input logic pt);
        in_valid    = 1'b1;
        branch_cond = c;
        pc          = pcv;
        a           = av;
        b           = bv;
        imm         = iv;
        pred_taken  = pt;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_taken", taken, 0);
        check("rst_mispredict", mispredict, 0);
        check("rst_target", target, 0);
        check("rst_next_pc", next_pc, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        pc = 32'h0; a = 32'h0; b = 32'h0; imm = 32'h0; branch_cond = 3'd0;
        pred_taken = 1'b0; lookup_pc = 32'h40;
        model_reset();
        do_reset();

        tick();
        check("t4_lookup_after_reset", lookup_taken, 0);

        // All eight condition codes on a=-1, b=1
        for (int i = 0; i < 8; i++) begin
            set_req(3'(t1_codes[i]), 32'h100 + 32'(i * 4), 32'hFFFF_FFFF, 32'h1, 32'h20, 1'b0);
            tick();
            check("t1_code_taken", taken, 64'(t1_exp[i]));
        end
        in_valid = 1'b0;
        tick();

        // Wrap-around of target and sequential PC
        set_req(3'd3, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h8, 1'b1);
        tick();
        check("t2_always_target", target, 32'h0000_0004);
        check("t2_always_next_pc", next_pc, 32'h0000_0004);
        set_req(3'd2, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h8, 1'b0);
        tick();
        check("t2_never_next_pc", next_pc, 32'h0000_0000);
        in_valid = 1'b0;
        tick();

        // Back-pressure holds the result and blocks the next request
        out_ready = 1'b0;
        set_req(3'd0, 32'h200, 32'h5, 32'h5, 32'h10, 1'b1);
        tick();
        set_req(3'd1, 32'h300, 32'h5, 32'h6, 32'h40, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_in_ready_low", in_ready, 0);
            check("t3_hold_target", target, 32'h210);
        end
        out_ready = 1'b1;
        tick();
        check("t3_second_target", target, 32'h340);
        for (int i = 0; i < 4; i++) begin
            set_req(3'd3, 32'h400 + 32'(i * 16), 32'h0, 32'h0, 32'h4, 1'b1);
            tick();
            check("t3_b2b_valid", out_valid, 1);
            check("t3_b2b_target", target, 32'h404 + 32'(i * 16));
        end
        in_valid = 1'b0;
        tick();

        // Predictor training at pc 0x40
        lookup_pc = 32'h40;
        set_req(3'd0, 32'h40, 32'h7, 32'h7, 32'h4, 1'b0);
        #1;
        check("t4_same_cycle_old", lookup_taken, 0);
        tick();
        check("t4_after_first", lookup_taken, 1);
        for (int i = 0; i < 3; i++) tick();
        set_req(3'd0, 32'h40, 32'h7, 32'h8, 32'h4, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        check("t4_after_not_taken", lookup_taken, 1);

        // Mispredict accounting and saturation of the narrow counters
        do_reset();
        set_req(3'd0, 32'h80, 32'h9, 32'h9, 32'h4, 1'b0);
        tick();
        check("t5_mispredict", mispredict, 1);
        check("t5_stat_mispred", stat_mispred, 1);
        check("t5_stat_branches", stat_branches, 1);
        for (int i = 0; i < 19; i++) tick();
        in_valid = 1'b0;
        tick();
        check("t5_cnt4_saturated", stat_branches4, 15);
        check("t5_cnt16_count", stat_branches, 20);

        // Flush drops the held result and the request presented with it
        out_ready = 1'b0;
        set_req(3'd1, 32'h44, 32'h1, 32'h2, 32'h8, 1'b1);
        tick();
        out_ready = 1'b1;
        flush     = 1'b1;
        lookup_pc = 32'h48;
        set_req(3'd0, 32'h48, 32'h3, 32'h3, 32'h8, 1'b1);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("t6_flush_out_valid", out_valid, 0);
        check("t6_flush_stats", stat_branches, 21);
        check("t6_flush_bht", lookup_taken, 0);
        tick();

        // Asynchronous reset while a result is held
        lookup_pc = 32'h80;
        out_ready = 1'b0;
        set_req(3'd0, 32'h80, 32'h1, 32'h1, 32'h4, 1'b1);
        tick();
        in_valid = 1'b0;
        check("t6_held_before_reset", out_valid, 1);
        check("t6_bht_trained", lookup_taken, 1);
        rst_n = 1'b0;
        #1;
        check("t6_async_out_valid", out_valid, 0);
        check("t6_async_out_valid_cnt4", out_valid4, 0);
        check("t6_async_bht", lookup_taken, 0);
        check("t6_async_stats", stat_branches, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] av;
            logic [31:0] bv;
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 15) == 0);
            branch_cond = 3'($urandom_range(0, 7));
            pred_taken  = 1'($urandom_range(0, 1));
            pc          = ($urandom_range(0, 3) == 0) ? $urandom
                        : ((($urandom & 32'hFFFF_FF00)) | 32'($urandom_range(0, 7) << 2));
            imm         = $urandom;
            lookup_pc   = 32'($urandom_range(0, 7) << 2);
            case ($urandom_range(0, 2))
                0: begin av = $urandom; bv = av; end
                1: begin av = edge_vals[$urandom_range(0, 5)]; bv = edge_vals[$urandom_range(0, 5)]; end
                default: begin av = $urandom; bv = $urandom; end
            endcase
            a = av;
            b = bv;
            tick();
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
